// File: rtl/left_rotation_serial.sv
// ============================================================================
// left_rotation_serial: rotates an operand left by s, one bit per clock, under
// a start/busy/done handshake. Optional macro: LEFT_ROTATION_FAST_EN (1-cycle
// barrel rotate instead of the serial loop).
// Revision: 1.0
// ============================================================================
`default_nettype none

module left_rotation_serial #(
  parameter int WIDTH = 8,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [SW-1:0]    s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] r;
  logic [SW-1:0]    cnt;

`ifdef LEFT_ROTATION_FAST_EN
  // The upper half of the doubled operand shifted by s is the rotated value.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v,
                                            input logic [SW-1:0] amt);
    logic [2*WIDTH-1:0] dbl;
    dbl  = {v, v} << amt;
    rotl = dbl[2*WIDTH-1:WIDTH];
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= s;
`ifdef LEFT_ROTATION_FAST_EN
            r     <= rotl(din, s);
            state <= DONE;
`else
            r     <= din;
            state <= (s == '0) ? DONE : ROT;
`endif
          end
        end
        ROT: begin
          r   <= {r[WIDTH-2:0], r[WIDTH-1]};
          cnt <= cnt - 1'b1;
          if (cnt == SW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign dout = r;

endmodule

`default_nettype wire

// File: tb/tb_left_rotation_serial.sv
// Self-checking bench for left_rotation_serial: directed steps, scoreboard of
// expected results popped on each done pulse.
`default_nettype none

module tb_left_rotation_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] din;
  logic [2:0] s;
  logic       busy;
  logic       done;
  logic [7:0] dout;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  left_rotation_serial #(.WIDTH(8), .SW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .s     (s),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  // Reference: bit i moves to position (i+sh) mod 8.
  function automatic logic [7:0] ref_rotl(input logic [7:0] d, input logic [2:0] sh);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) res[(i + int'(sh)) % 8] = d[i];
    return res;
  endfunction

  function automatic int exp_lat(input logic [2:0] sh);
`ifdef LEFT_ROTATION_FAST_EN
    return 1;
`else
    return int'(sh) + 1;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        chk("sb_dout", int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic run(input string tag, input logic [7:0] d, input logic [2:0] sh);
    int lat;
    logic [7:0] e;
    e = ref_rotl(d, sh);
    @(negedge clk);
    din = d; s = sh; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    din = ~d; s = ~sh;
    chk({tag, "_busy_rise"}, int'(busy), 1);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat(sh));
    @(posedge clk); #1;
    chk({tag, "_busy_fall"}, int'(busy), 0);
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_dout_hold"}, int'(dout), int'(e));
  endtask

  initial begin
    int t0, t1, cyc, npulse;
    rst_n = 1'b0; start = 1'b0; din = '0; s = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_dout", int'(dout), 0);
    @(negedge clk) rst_n = 1'b1;

    run("b4_s3", 8'hB4, 3'd3);
    chk("b4_s3_const", int'(dout), 8'hA5);
    run("3c_s0", 8'h3C, 3'd0);
    chk("3c_s0_const", int'(dout), 8'h3C);
    run("01_s7", 8'h01, 3'd7);
    chk("01_s7_const", int'(dout), 8'h80);
    run("80_s1", 8'h80, 3'd1);
    chk("80_s1_const", int'(dout), 8'h01);
    for (int i = 0; i < 6; i++) begin
      run("rand", 8'($urandom), 3'($urandom_range(0, 7)));
    end

    // start held high through the whole busy period.
    @(negedge clk);
    din = 8'hB4; s = 3'd3; start = 1'b1;
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    din = 8'hFF; s = 3'd5;
    exp_q.push_back(8'hFF);
    cyc = 0; t0 = -1; t1 = -1;
    while (t1 < 0 && cyc < 40) begin
      if (done === 1'b1) begin
        if (t0 < 0) t0 = cyc;
        else if (cyc > t0 + 1 || t1 >= 0) t1 = cyc;
      end
      if (t1 < 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk("held_first_lat", t0 + 1, exp_lat(3'd3));
`ifdef LEFT_ROTATION_FAST_EN
    chk("held_spacing", t1 - t0, 2);
`else
    chk("held_spacing", t1 - t0, 7);
`endif
    chk("held_second_dout", int'(dout), 8'hFF);
    @(posedge clk); #1;

    // Reset asserted at E+3 aborts the request.
    @(negedge clk);
    din = 8'hB4; s = 3'd6; start = 1'b1;
`ifdef LEFT_ROTATION_FAST_EN
    exp_q.push_back(ref_rotl(8'hB4, 3'd6));
`endif
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_dout", int'(dout), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk) rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) npulse++;
    end
    chk("abort_no_done", npulse, 0);
    run("after_abort", 8'h5A, 3'd2);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
